// File: rtl/rtc_pkg.sv
// Shared RTC definitions: set-mode encoding used by the control and display blocks.
package rtc_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } rtc_mode_e;

  function automatic logic is_set_mode(input rtc_mode_e m);
    return (m == MODE_SET_HR) || (m == MODE_SET_MIN);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer; emits the settled level and a rise strobe.
module btn_debounce #(
  parameter int unsigned DB_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;

  // Level flips only after DB_CYC consecutive synchronized samples disagree with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_o  <= 1'b0;
      if (sync2_q == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYC - 1)) begin
        cnt_q   <= '0;
        level_o <= sync2_q;
        rise_o  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// RTC time-set controller: seconds prescaler, RUN/SET_HR/SET_MIN mode FSM, increment
// strobes with auto-repeat, idle timeout and field blink.
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DB_CYC     = 1_000_000,
  parameter int unsigned REP_DELAY  = 25_000_000,
  parameter int unsigned REP_PERIOD = 5_000_000,
  parameter int unsigned TIMEOUT_S  = 30
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_mode_i,
  input  logic       btn_up_i,
  output logic       sec_tick_o,
  output logic       inc_hr_o,
  output logic       inc_min_o,
  output logic       clr_sec_o,
  output logic [1:0] mode_o,
  output logic       blink_o
);

  localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);
  localparam int unsigned IW      = $clog2(TIMEOUT_S + 1);

  logic mode_rise, up_rise, up_lvl;

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_mode_i),
    .level_o (),
    .rise_o  (mode_rise)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_up (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_up_i),
    .level_o (up_lvl),
    .rise_o  (up_rise)
  );

  rtc_mode_e     state_q, state_nxt;
  logic [PW-1:0] presc_q;
  logic [IW-1:0] idle_q;
  logic [RW-1:0] rep_cnt_q;
  logic          rep_act_q, rep_per_q;

  logic in_set, wrap, timeout;
  assign in_set  = is_set_mode(state_q);
  assign wrap    = (presc_q == PW'(TICK_DIV - 1));
  assign timeout = in_set && wrap && (idle_q == IW'(TIMEOUT_S - 1));
  assign mode_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= MODE_RUN;
    else       state_q <= state_nxt;
  end

  // Mode press wins over the idle timeout; the unused code falls back to RUN.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      MODE_RUN:     if (mode_rise) state_nxt = MODE_SET_HR;
      MODE_SET_HR:  if (mode_rise) state_nxt = MODE_SET_MIN;
                    else if (timeout) state_nxt = MODE_RUN;
      MODE_SET_MIN: if (mode_rise || timeout) state_nxt = MODE_RUN;
      default:      state_nxt = MODE_RUN;
    endcase
  end

  logic          state_chg_c, up_acc_c, rep_fire_c, inc_c;
  logic          sec_tick_c, inc_hr_c, inc_min_c, clr_c, blink_c;
  logic          rep_act_nxt_c, rep_per_nxt_c;
  logic [RW-1:0] rep_lim_c, rep_cnt_nxt_c;
  logic [PW-1:0] presc_nxt_c;
  logic [IW-1:0] idle_nxt_c;

  always_comb begin
    state_chg_c   = (state_nxt != state_q);
    up_acc_c      = 1'b0;
    rep_fire_c    = 1'b0;
    inc_c         = 1'b0;
    sec_tick_c    = 1'b0;
    inc_hr_c      = 1'b0;
    inc_min_c     = 1'b0;
    clr_c         = 1'b0;
    blink_c       = 1'b0;
    rep_lim_c     = rep_per_q ? RW'(REP_PERIOD) : RW'(REP_DELAY);
    rep_act_nxt_c = rep_act_q;
    rep_per_nxt_c = rep_per_q;
    rep_cnt_nxt_c = rep_cnt_q;
    presc_nxt_c   = presc_q + PW'(1);
    idle_nxt_c    = idle_q;

    up_acc_c   = in_set && up_rise && !state_chg_c;
    rep_fire_c = rep_act_q && up_lvl && !state_chg_c && (rep_cnt_q == rep_lim_c);
    inc_c      = up_acc_c || rep_fire_c;
    inc_hr_c   = inc_c && (state_q == MODE_SET_HR);
    inc_min_c  = inc_c && (state_q == MODE_SET_MIN);
    sec_tick_c = (state_q == MODE_RUN) && wrap;
    clr_c      = in_set && (state_nxt == MODE_RUN);

    if (wrap || clr_c) presc_nxt_c = '0;

    // Auto-repeat pulses count as activity, so holding up never times out.
    if (!in_set || state_chg_c || inc_c) idle_nxt_c = '0;
    else if (wrap)                       idle_nxt_c = idle_q + IW'(1);

    if (!in_set || state_chg_c || !up_lvl) begin
      rep_act_nxt_c = 1'b0;
      rep_per_nxt_c = 1'b0;
      rep_cnt_nxt_c = '0;
    end else if (up_acc_c) begin
      rep_act_nxt_c = 1'b1;
      rep_per_nxt_c = 1'b0;
      rep_cnt_nxt_c = RW'(1);
    end else if (rep_fire_c) begin
      rep_per_nxt_c = 1'b1;
      rep_cnt_nxt_c = RW'(1);
    end else if (rep_act_q) begin
      rep_cnt_nxt_c = rep_cnt_q + RW'(1);
    end

    blink_c = is_set_mode(state_nxt) && (presc_nxt_c < PW'(TICK_DIV / 2));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      idle_q     <= '0;
      rep_cnt_q  <= '0;
      rep_act_q  <= 1'b0;
      rep_per_q  <= 1'b0;
      sec_tick_o <= 1'b0;
      inc_hr_o   <= 1'b0;
      inc_min_o  <= 1'b0;
      clr_sec_o  <= 1'b0;
      blink_o    <= 1'b0;
    end else begin
      presc_q    <= presc_nxt_c;
      idle_q     <= idle_nxt_c;
      rep_cnt_q  <= rep_cnt_nxt_c;
      rep_act_q  <= rep_act_nxt_c;
      rep_per_q  <= rep_per_nxt_c;
      sec_tick_o <= sec_tick_c;
      inc_hr_o   <= inc_hr_c;
      inc_min_o  <= inc_min_c;
      clr_sec_o  <= clr_c;
      blink_o    <= blink_c;
    end
  end

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Bench for rtc_set_ctrl: directed scenarios plus random button traffic against a behavioural model.
module tb_rtc_set_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int TO = 3;

  logic       clk_i = 1'b0;
  logic       rst_i, btn_mode_i, btn_up_i;
  logic       sec_tick_o, inc_hr_o, inc_min_o, clr_sec_o, blink_o;
  logic [1:0] mode_o;

  rtc_set_ctrl #(
    .TICK_DIV(TD), .DB_CYC(DB), .REP_DELAY(RD), .REP_PERIOD(RP), .TIMEOUT_S(TO)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .btn_mode_i (btn_mode_i),
    .btn_up_i   (btn_up_i),
    .sec_tick_o (sec_tick_o),
    .inc_hr_o   (inc_hr_o),
    .inc_min_o  (inc_min_o),
    .clr_sec_o  (clr_sec_o),
    .mode_o     (mode_o),
    .blink_o    (blink_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural model: mode as 0/1/2, prescaler phase, idle wraps, hold age since press.
  int m_mode, m_phase, m_idle, m_age;
  bit m_rep_on;
  bit h0 [2], h1 [2], lvl [2], rise [2];
  bit samp [2][DB];
  int nsamp [2];
  bit e_tick, e_hr, e_min, e_clr, e_blink;
  int e_mode;

  always @(posedge clk_i) begin : p_model
    bit mr, ur, ul, in_set, wrap, changed, acc, fire, inc, s, alld;
    bit rawv [2];
    int nm, a;
    rawv[0] = btn_mode_i;
    rawv[1] = btn_up_i;
    if (rst_i) begin
      m_mode = 0; m_phase = 0; m_idle = 0; m_age = 0; m_rep_on = 0;
      for (int b = 0; b < 2; b++) begin
        h0[b] = 0; h1[b] = 0; lvl[b] = 0; rise[b] = 0; nsamp[b] = 0;
      end
      e_tick = 0; e_hr = 0; e_min = 0; e_clr = 0; e_blink = 0; e_mode = 0;
    end else begin
      mr = rise[0]; ur = rise[1]; ul = lvl[1];
      in_set = (m_mode != 0);
      wrap   = (m_phase == TD - 1);
      nm = m_mode;
      if (mr) nm = (m_mode + 1) % 3;
      else if (in_set && wrap && m_idle + 1 >= TO) nm = 0;
      changed = (nm != m_mode);
      acc  = in_set && ur && !changed;
      fire = 0;
      if (m_rep_on && ul && !changed) begin
        a = m_age + 1;
        fire = (a == RD) || (a > RD && (a - RD) % RP == 0);
      end
      inc    = acc || fire;
      e_hr   = inc && (m_mode == 1);
      e_min  = inc && (m_mode == 2);
      e_tick = (m_mode == 0) && wrap;
      e_clr  = in_set && (nm == 0);
      if (!in_set || changed || !ul) begin m_rep_on = 0; m_age = 0; end
      else if (acc) begin m_rep_on = 1; m_age = 0; end
      else if (m_rep_on) m_age++;
      if (!in_set || changed || inc) m_idle = 0;
      else if (wrap) m_idle++;
      m_phase = (e_clr || wrap) ? 0 : m_phase + 1;
      m_mode  = nm;
      e_mode  = nm;
      e_blink = (nm != 0) && (m_phase < TD / 2);
      // A button level changes once the last DB synchronized samples all disagree with it.
      for (int b = 0; b < 2; b++) begin
        s = h1[b]; h1[b] = h0[b]; h0[b] = rawv[b];
        for (int i = DB - 1; i > 0; i--) samp[b][i] = samp[b][i-1];
        samp[b][0] = s;
        if (nsamp[b] < DB) nsamp[b]++;
        alld = 1;
        for (int i = 0; i < DB; i++) if (samp[b][i] == lvl[b]) alld = 0;
        rise[b] = 0;
        if (nsamp[b] >= DB && alld) begin lvl[b] = s; rise[b] = s; end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    cyc++;
    chk("sec_tick", sec_tick_o, e_tick);
    chk("inc_hr",   inc_hr_o,   e_hr);
    chk("inc_min",  inc_min_o,  e_min);
    chk("clr_sec",  clr_sec_o,  e_clr);
    chk("mode",     mode_o,     e_mode);
    chk("blink",    blink_o,    e_blink);
    chk("inc_excl", inc_hr_o & inc_min_o, 0);
  endtask

  task automatic press_mode();
    btn_mode_i = 1'b1;
    repeat (8) tick();
    btn_mode_i = 1'b0;
    repeat (8) tick();
  endtask

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int c0, clr_t, tick_t, clr_n, min_n, seen;
    int hr_t[$];
    int exp_rep[5];
    exp_rep[0] = 7; exp_rep[1] = 27; exp_rep[2] = 32; exp_rep[3] = 37; exp_rep[4] = 42;

    rst_i = 1'b1; btn_mode_i = 1'b0; btn_up_i = 1'b0;
    repeat (3) tick();
    chk("rst_mode", mode_o, 0);
    chk("rst_blink", blink_o, 0);
    rst_i = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      tick();
      chk("tick_at", sec_tick_o, (n % 10 == 0));
    end

    // Two-cycle glitch on both buttons must not be accepted.
    btn_up_i = 1'b1; btn_mode_i = 1'b1;
    repeat (2) tick();
    btn_up_i = 1'b0; btn_mode_i = 1'b0;
    repeat (10) tick();
    chk("glitch_mode", mode_o, 0);

    btn_mode_i = 1'b1;
    repeat (6) tick();
    chk("mode_pre", mode_o, 0);
    tick();
    chk("mode_set_hr", mode_o, 1);
    repeat (3) tick();
    btn_mode_i = 1'b0;
    repeat (8) tick();

    // Hold up for 40 cycles in SET_HR and log each increment.
    c0 = cyc; min_n = 0;
    btn_up_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 40) btn_up_i = 1'b0;
      tick();
      if (inc_hr_o) hr_t.push_back(cyc - c0);
      if (inc_min_o) min_n++;
    end
    chk("rep_count", hr_t.size(), 5);
    for (int i = 0; i < 5; i++) chk("rep_time", (i < hr_t.size()) ? hr_t[i] : -1, exp_rep[i]);
    chk("rep_no_min", min_n, 0);

    // Simultaneous mode and up: state advances, no increment.
    btn_mode_i = 1'b1; btn_up_i = 1'b1; seen = 0;
    repeat (7) begin tick(); seen += int'(inc_hr_o) + int'(inc_min_o); end
    chk("prio_mode", mode_o, 2);
    chk("prio_noinc", seen, 0);
    repeat (5) tick();
    btn_mode_i = 1'b0; btn_up_i = 1'b0;

    // Idle timeout from SET_MIN.
    clr_n = 0; clr_t = -1; tick_t = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (clr_sec_o) begin clr_n++; clr_t = cyc; end
      if (sec_tick_o && clr_t >= 0 && tick_t < 0) tick_t = cyc;
    end
    chk("to_clr_count", clr_n, 1);
    chk("to_mode", mode_o, 0);
    chk("to_tick_gap", tick_t - clr_t, 10);

    // Reset in the middle of SET_MIN auto-repeat.
    press_mode();
    press_mode();
    chk("enter_min", mode_o, 2);
    btn_up_i = 1'b1; min_n = 0;
    repeat (30) begin tick(); min_n += int'(inc_min_o); end
    chk("min_before_rst", min_n, 2);
    rst_i = 1'b1;
    clr_n = 0; seen = 0;
    repeat (3) begin tick(); clr_n += int'(clr_sec_o); seen += int'(inc_hr_o) + int'(inc_min_o); end
    rst_i = 1'b0;
    tick_t = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      clr_n += int'(clr_sec_o);
      seen  += int'(inc_hr_o) + int'(inc_min_o);
      if (sec_tick_o && tick_t < 0) tick_t = n;
    end
    chk("rst_mode_run", mode_o, 0);
    chk("rst_no_clr", clr_n, 0);
    chk("rst_no_inc", seen, 0);
    chk("rst_first_tick", tick_t, 10);
    btn_up_i = 1'b0;
    repeat (10) tick();

    // Random button traffic with occasional resets.
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
      end
      btn_mode_i = ($urandom_range(0, 3) == 0);
      btn_up_i   = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_set_ctrl.md
RTC_SET_CTRL -- requirements
Module: rtc_set_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50_000_000: clk_i cycles per second.
REQ-002 SHALL have parameter DB_CYC, default 1_000_000: consecutive stable cycles required for the debounce to accept a new level.
REQ-003 SHALL have parameter REP_DELAY, default 25_000_000: up-button hold cycles before auto-repeat starts.
REQ-004 SHALL have parameter REP_PERIOD, default 5_000_000: cycles between auto-repeat pulses.
REQ-005 SHALL have parameter TIMEOUT_S, default 30: idle seconds in a set mode before automatic return to RUN.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port btn_mode_i, input, 1 bit: raw, asynchronous mode button, active-high.
REQ-009 SHALL have port btn_up_i, input, 1 bit: raw, asynchronous increment button, active-high.
REQ-010 SHALL have port sec_tick_o, output, 1 bit: one-cycle seconds strobe to the time counter.
REQ-011 SHALL have port inc_hr_o, output, 1 bit: one-cycle hour-increment strobe.
REQ-012 SHALL have port inc_min_o, output, 1 bit: one-cycle minute-increment strobe.
REQ-013 SHALL have port clr_sec_o, output, 1 bit: one-cycle strobe that clears seconds.
REQ-014 SHALL have port mode_o, output, 2 bits: current state (RUN=00, SET_HR=01, SET_MIN=10).
REQ-015 SHALL have port blink_o, output, 1 bit: display blink enable for the field being edited.

Function
REQ-016 SHALL pass each button through a 2-FF synchronizer, then a debouncer whose level changes only after DB_CYC consecutive equal samples; a press SHALL produce a strobe exactly DB_CYC+3 cycles after the raw edge.
REQ-017 SHALL implement the FSM: RUN -mode press-> SET_HR -mode press-> SET_MIN -mode press-> RUN; code 11 is unreachable and SHALL recover to RUN on the next cycle.
REQ-018 SHALL run a prescaler 0..TICK_DIV-1 in all states; in RUN, sec_tick_o SHALL pulse for one cycle when the prescaler equals TICK_DIV-1; in set modes, sec_tick_o SHALL be 0.
REQ-019 SHALL, on the SET_MIN->RUN transition, pulse clr_sec_o for one cycle and load the prescaler with 0 in the same cycle.
REQ-020 SHALL, in SET_HR or SET_MIN, pulse inc_hr_o or inc_min_o respectively for one cycle on each debounced up rising edge.
REQ-021 SHALL, while up is held debounced-high, emit the first repeat pulse REP_DELAY cycles after the initial pulse, and then one pulse every REP_PERIOD cycles until release.
REQ-022 SHALL ignore up presses in RUN: no strobes, and the repeat counter is held at 0.
REQ-023 SHALL give mode priority when debounced mode and up edges land in the same cycle: the state advances, no inc strobe is issued, and repeat is cancelled.
REQ-024 SHALL cancel repeat on any state change.
REQ-025 SHALL keep an idle-seconds counter in set modes, incremented at each prescaler wrap and cleared on any accepted press; on reaching TIMEOUT_S, the FSM SHALL return to RUN with clr_sec_o pulsed, exactly as in REQ-019.
REQ-026 SHALL drive blink_o=1 in set modes while prescaler < TICK_DIV/2, and 0 otherwise; in RUN, blink_o=0.
REQ-027 SHALL never assert inc_hr_o and inc_min_o in the same cycle; all strobes SHALL be registered outputs.

Reset
REQ-028 SHALL, while rst_i=1 at a clock edge, set: state RUN; prescaler, repeat, idle and debounce counters 0; synchronizers and debounced levels 0; all strobes 0; blink_o=0; mode_o=00.
REQ-029 SHALL abort any set-mode or repeat activity when reset is asserted mid-operation, with no clr_sec_o pulse; after release, the first sec_tick_o SHALL occur in the TICK_DIV-th cycle.

Structure
REQ-030 SHALL take the mode encoding (RUN/SET_HR/SET_MIN) from the shared package rtc_pkg, which the display block also uses.
REQ-031 SHALL place synchronizer plus debouncer in sub-module btn_debounce (parameter DB_CYC; outputs level and rise strobe), instantiated once per button.

Verification (TICK_DIV=10, DB_CYC=4, REP_DELAY=20, REP_PERIOD=5, TIMEOUT_S=3)
REQ-032 SHALL verify that after reset release, with no buttons, sec_tick_o pulses at cycles 10, 20, 30 and all other outputs stay 0.
REQ-033 SHALL verify that a 2-cycle up glitch produces no strobe, and that a clean mode press moves mode_o 00->01 exactly 7 cycles after the raw edge.
REQ-034 SHALL verify that in SET_HR, holding up for 40 cycles after debounce gives inc_hr_o at t, t+20, t+25, t+30, t+35 and no inc_min_o.
REQ-035 SHALL verify that mode and up pressed in the same cycle in SET_HR give mode_o=10 with no inc strobe.
REQ-036 SHALL verify that in SET_MIN, idling for 3 prescaler wraps returns mode_o to 00 with a single clr_sec_o pulse, and that the next sec_tick_o comes 10 cycles later.
REQ-037 SHALL verify that rst_i asserted mid-repeat in SET_MIN gives mode_o=00, no further strobes and no clr_sec_o.
